wramp_serial_tx: RTL

//  Memory-mapped serial transmitter; responds to wramp CPU bus cycles (CPU is initiator, this is responder).

---
 rtl/wramp_serial_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wramp_serial_tx.sv
// rtl/wramp_serial_tx.sv - memory-mapped 8N1/8E1 serial transmitter with TX FIFO
// Optional even-parity bit enabled by defining WRAMP_SERIAL_PARITY_EN.
module wramp_serial_tx #(
  parameter logic [19:0] BASE_ADDR   = 20'h70000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk,
  input  logic        rst_async_n,
  input  logic [19:0] mem_address,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_value,
  output logic        sp_sel,
  output logic [31:0] sp_read_value,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef WRAMP_SERIAL_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, fifo_count;
  logic        full, empty;
  logic [15:0] baud_div, div_lat, bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        overrun;
  logic [19:0] offset;
  logic        hit_txdata, hit_status, hit_baud;
  logic        push, pop, bit_done;
  logic [31:0] status_word;
  logic        unused_bits;

  // Unsigned wrap makes addresses below BASE_ADDR land far above 2.
  assign offset     = mem_address - BASE_ADDR;
  assign sp_sel     = offset < 20'd3;
  assign hit_txdata = mem_write_en && sp_sel && (offset[1:0] == 2'd0);
  assign hit_status = mem_write_en && sp_sel && (offset[1:0] == 2'd1);
  assign hit_baud   = mem_write_en && sp_sel && (offset[1:0] == 2'd2);
  assign unused_bits = ^mem_write_value[31:16];

  assign fifo_count = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = hit_txdata && !full;
  assign bit_done   = (bit_cnt == 16'd0);

  assign status_word = {16'h0000, 8'(fifo_count), 3'b000, PARITY_EN, overrun,
                        (state != S_IDLE), empty, full};

  always_comb begin
    sp_read_value = 32'h0;
    if (sp_sel) begin
      case (offset[1:0])
        2'd1:    sp_read_value = status_word;
        2'd2:    sp_read_value = {16'h0000, baud_div};
        default: sp_read_value = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // A pop in STOP chains the next frame with no idle bit in between.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: if (bit_done) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
`ifdef WRAMP_SERIAL_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[bit_idx];
`ifdef WRAMP_SERIAL_PARITY_EN
      S_PARITY: tx = ^shreg;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // Divider is latched at pop so BAUDDIV writes only affect later frames.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      rd_ptr  <= '0;
      shreg   <= 8'h00;
      div_lat <= 16'h0000;
      bit_cnt <= 16'h0000;
      bit_idx <= 3'd0;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + 1'b1;
      shreg   <= fifo_mem[rd_ptr[AW-1:0]];
      div_lat <= baud_div;
      bit_cnt <= baud_div;
      bit_idx <= 3'd0;
    end else if (state != S_IDLE) begin
      if (bit_done) begin
        bit_cnt <= div_lat;
        if (state == S_DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        bit_cnt <= bit_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wr_ptr   <= '0;
      overrun  <= 1'b0;
      baud_div <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (hit_txdata && full) overrun <= 1'b1;
      else if (hit_status)    overrun <= 1'b0;
      if (hit_baud) baud_div <= mem_write_value[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= mem_write_value[7:0];
  end

endmodule
